// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux (addressed / round-robin / broadcast) with one-entry buffer per output.
// Latency: beat visible on out_valid/out_data from the accepting edge; 1-cycle register delay.
// Backpressure: in_ready is combinational from target buffer(s) free state; a pop frees a slot on the same edge.
module stream_demux #(
    parameter  int WIDTH = 8,
    parameter  int N_OUT = 4,
    localparam int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [SEL_W-1:0]       rr_ptr,
    output logic                   drop_err
);

    localparam logic [1:0] MODE_ADDR  = 2'b00;
    localparam logic [1:0] MODE_RR    = 2'b01;
    localparam logic [1:0] MODE_BCAST = 2'b10;

    logic [N_OUT-1:0]            free;
    logic [N_OUT-1:0]            hit_sel;
    logic [N_OUT-1:0]            hit_rr;
    logic [N_OUT-1:0]            load;
    logic                        sel_ok;
    logic                        accept;
    logic [N_OUT-1:0][WIDTH-1:0] data_q;

    assign free     = ~out_valid | out_ready;
    assign sel_ok   = 32'(in_sel) < N_OUT;
    assign accept   = in_valid && in_ready;
    assign out_data = data_q;

    // One-hot decodes avoid indexing past N_OUT when it is not a power of two.
    always_comb begin
        hit_sel = '0;
        hit_rr  = '0;
        for (int k = 0; k < N_OUT; k++) begin
            hit_sel[k] = (in_sel == SEL_W'(k));
            hit_rr[k]  = (rr_ptr == SEL_W'(k));
        end
    end

    always_comb begin
        in_ready = 1'b0;
        load     = '0;
        case (mode)
            MODE_ADDR: begin
                in_ready = sel_ok ? |(hit_sel & free) : 1'b1;
                load     = sel_ok ? hit_sel : '0;
            end
            MODE_RR: begin
                in_ready = |(hit_rr & free);
                load     = hit_rr;
            end
            MODE_BCAST: begin
                in_ready = &free;
                load     = '1;
            end
            default: begin
                in_ready = 1'b0;
                load     = '0;
            end
        endcase
        if (!rst_n) in_ready = 1'b0;
        if (!accept) load = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            data_q    <= '0;
            rr_ptr    <= '0;
            drop_err  <= 1'b0;
        end else begin
            for (int k = 0; k < N_OUT; k++) begin
                if (load[k]) begin
                    out_valid[k] <= 1'b1;
                    data_q[k]    <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
            if (accept && mode == MODE_RR)
                rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + SEL_W'(1);
            drop_err <= accept && mode == MODE_ADDR && !sel_ok;
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance driven from a vector table,
// a 3-channel instance for round-robin wrap and out-of-range select, plus asynchronous reset.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 4-channel instance
    logic [1:0]  m4_mode;
    logic        m4_in_valid, m4_in_ready;
    logic [7:0]  m4_in_data;
    logic [1:0]  m4_in_sel;
    logic [3:0]  m4_out_valid, m4_out_ready;
    logic [31:0] m4_out_data;
    logic [1:0]  m4_rr_ptr;
    logic        m4_drop_err;

    // 3-channel instance
    logic [1:0]  m3_mode;
    logic        m3_in_valid, m3_in_ready;
    logic [7:0]  m3_in_data;
    logic [1:0]  m3_in_sel;
    logic [2:0]  m3_out_valid, m3_out_ready;
    logic [23:0] m3_out_data;
    logic [1:0]  m3_rr_ptr;
    logic        m3_drop_err;

    stream_demux #(.WIDTH(8), .N_OUT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .mode(m4_mode),
        .in_valid(m4_in_valid), .in_ready(m4_in_ready), .in_data(m4_in_data), .in_sel(m4_in_sel),
        .out_valid(m4_out_valid), .out_ready(m4_out_ready), .out_data(m4_out_data),
        .rr_ptr(m4_rr_ptr), .drop_err(m4_drop_err)
    );

    stream_demux #(.WIDTH(8), .N_OUT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .mode(m3_mode),
        .in_valid(m3_in_valid), .in_ready(m3_in_ready), .in_data(m3_in_data), .in_sel(m3_in_sel),
        .out_valid(m3_out_valid), .out_ready(m3_out_ready), .out_data(m3_out_data),
        .rr_ptr(m3_rr_ptr), .drop_err(m3_drop_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0] mode;
        logic       vld;
        logic [1:0] sel;
        logic [7:0] dat;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
        logic [1:0] exp_rr;
        logic       exp_drop;
        int         ch;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // mode vld sel dat ordy | rdy ov rr drop ch dat
        tbl[0]  = '{2'b00, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1, 4'b0100, 2'd0, 1'b0, 2, 8'hA5};
        tbl[1]  = '{2'b00, 1'b1, 2'd2, 8'h5A, 4'b0000, 1'b0, 4'b0100, 2'd0, 1'b0, 2, 8'hA5};
        tbl[2]  = '{2'b00, 1'b1, 2'd2, 8'h5A, 4'b0100, 1'b1, 4'b0100, 2'd0, 1'b0, 2, 8'h5A};
        tbl[3]  = '{2'b00, 1'b0, 2'd0, 8'h00, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 2, 8'h5A};
        tbl[4]  = '{2'b01, 1'b1, 2'd0, 8'h11, 4'b0000, 1'b1, 4'b0001, 2'd1, 1'b0, 0, 8'h11};
        tbl[5]  = '{2'b01, 1'b1, 2'd0, 8'h22, 4'b0000, 1'b1, 4'b0011, 2'd2, 1'b0, 1, 8'h22};
        tbl[6]  = '{2'b00, 1'b1, 2'd0, 8'h33, 4'b0000, 1'b0, 4'b0011, 2'd2, 1'b0, 0, 8'h11};
        tbl[7]  = '{2'b10, 1'b1, 2'd0, 8'h3C, 4'b0011, 1'b1, 4'b1111, 2'd2, 1'b0, 3, 8'h3C};
        tbl[8]  = '{2'b10, 1'b1, 2'd0, 8'h44, 4'b0111, 1'b0, 4'b1000, 2'd2, 1'b0, 0, 8'h3C};
        tbl[9]  = '{2'b10, 1'b1, 2'd0, 8'h3C, 4'b1000, 1'b1, 4'b1111, 2'd2, 1'b0, 1, 8'h3C};
        tbl[10] = '{2'b11, 1'b1, 2'd0, 8'h99, 4'b0101, 1'b0, 4'b1010, 2'd2, 1'b0, 1, 8'h3C};
        tbl[11] = '{2'b11, 1'b1, 2'd0, 8'h99, 4'b1010, 1'b0, 4'b0000, 2'd2, 1'b0, 3, 8'h3C};
        tbl[12] = '{2'b01, 1'b1, 2'd0, 8'h55, 4'b0000, 1'b1, 4'b0100, 2'd3, 1'b0, 2, 8'h55};
        tbl[13] = '{2'b01, 1'b1, 2'd0, 8'h66, 4'b0100, 1'b1, 4'b1000, 2'd0, 1'b0, 3, 8'h66};
        tbl[14] = '{2'b01, 1'b1, 2'd0, 8'h77, 4'b0000, 1'b1, 4'b1001, 2'd1, 1'b0, 0, 8'h77};

        rst_n = 1'b0;
        m4_mode = 2'b00; m4_in_valid = 1'b0; m4_in_data = '0; m4_in_sel = '0; m4_out_ready = '0;
        m3_mode = 2'b00; m3_in_valid = 1'b0; m3_in_data = '0; m3_in_sel = '0; m3_out_ready = '0;

        #3;
        check("rst_out_valid", 32'(m4_out_valid), 32'h0);
        check("rst_in_ready",  32'(m4_in_ready),  32'h0);
        check("rst_rr_ptr",    32'(m4_rr_ptr),    32'h0);
        check("rst_drop_err",  32'(m4_drop_err),  32'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            m4_mode = tbl[i].mode; m4_in_valid = tbl[i].vld; m4_in_sel = tbl[i].sel;
            m4_in_data = tbl[i].dat; m4_out_ready = tbl[i].ordy;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(m4_in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk); #1;
            check($sformatf("v%0d_out_valid", i), 32'(m4_out_valid), 32'(tbl[i].exp_ov));
            check($sformatf("v%0d_rr_ptr", i),    32'(m4_rr_ptr),    32'(tbl[i].exp_rr));
            check($sformatf("v%0d_drop_err", i),  32'(m4_drop_err),  32'(tbl[i].exp_drop));
            check($sformatf("v%0d_out_data", i),  32'(m4_out_data[tbl[i].ch*8 +: 8]), 32'(tbl[i].exp_dat));
        end

        // Fill all buffers, then assert reset between edges.
        m4_mode = 2'b10; m4_in_valid = 1'b1; m4_in_data = 8'hEE; m4_out_ready = 4'b1001;
        #1 check("fill_in_ready", 32'(m4_in_ready), 32'h1);
        @(posedge clk); #1;
        check("fill_out_valid", 32'(m4_out_valid), 32'hF);
        m4_in_valid = 1'b0; m4_out_ready = 4'b0000;
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(m4_out_valid), 32'h0);
        check("arst_out_data",  m4_out_data,       32'h0);
        check("arst_rr_ptr",    32'(m4_rr_ptr),    32'h0);
        check("arst_in_ready",  32'(m4_in_ready),  32'h0);
        #2 rst_n = 1'b1;
        m4_mode = 2'b00; m4_in_sel = 2'd0;
        #1 check("post_rst_in_ready", 32'(m4_in_ready), 32'h1);
        @(posedge clk); #1;

        // Round-robin wrap over 3 channels.
        m3_mode = 2'b01; m3_out_ready = 3'b111; m3_in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            m3_in_data = 8'h10 + 8'(i);
            #1 check($sformatf("rr%0d_in_ready", i), 32'(m3_in_ready), 32'h1);
            @(posedge clk); #1;
            check($sformatf("rr%0d_out_valid", i), 32'(m3_out_valid), 32'(3'b001 << (i % 3)));
            check($sformatf("rr%0d_out_data", i), 32'(m3_out_data[(i % 3)*8 +: 8]), 32'(8'h10 + 8'(i)));
        end
        check("rr_final_ptr", 32'(m3_rr_ptr), 32'h1);

        // Out-of-range select on 3 channels.
        m3_mode = 2'b00; m3_in_sel = 2'd3; m3_in_data = 8'h99; m3_out_ready = 3'b000;
        #1 check("bad_sel_in_ready", 32'(m3_in_ready), 32'h1);
        @(posedge clk); #1;
        check("bad_sel_out_valid", 32'(m3_out_valid), 32'h1);
        check("bad_sel_drop_hi",   32'(m3_drop_err),  32'h1);
        check("bad_sel_data_ch0",  32'(m3_out_data[7:0]), 32'h16);
        m3_in_valid = 1'b0;
        @(posedge clk); #1;
        check("bad_sel_drop_lo",   32'(m3_drop_err),  32'h0);
        check("bad_sel_rr_hold",   32'(m3_rr_ptr),    32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
# stream_demux

Parametrised, registered 1-to-N stream demultiplexer with a valid/ready handshake on every port. It is the successor to the gate-level 1-to-4 demux: data width and output count are parameters, and each output has a one-entry holding buffer. It supports addressed, round-robin and broadcast routing, and flags beats that address a non-existent channel. It sits between a single producer and N independent consumers, such as lane fan-out or work distribution.

## Interface

- WIDTH, 8, data bits per beat (≥1)
- N_OUT, 4, number of output channels (≥2; need not be a power of two)
- SEL_W, $clog2(N_OUT), local (derived) parameter; width of select/pointer

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  routing mode: 00 addressed, 01 round-robin, 10 broadcast, 11 reserved
- in_valid  in  1  producer beat valid
- in_ready  out  1  demux can take the beat this cycle
- in_data  in  WIDTH  producer data
- in_sel  in  SEL_W  target channel; used in addressed mode only
- out_valid  out  N_OUT  bit k: channel k buffer holds a beat
- out_ready  in  N_OUT  bit k: consumer k takes the beat
- out_data  out  N_OUT*WIDTH  channel k at [k*WIDTH +: WIDTH]
- rr_ptr  out  SEL_W  next round-robin target
- drop_err  out  1  one-cycle pulse: an addressed beat with in_sel ≥ N_OUT was accepted and discarded

## Operation

- Per-channel buffer: a single register plus a full flag. The full flag drives out_valid[k].
- free[k] = !out_valid[k] || out_ready[k]. A pop and a push in the same cycle are allowed, giving full throughput.
- Consumer pop on channel k: out_valid[k] && out_ready[k] at the edge. The buffer empties unless it is refilled on the same edge.
- Accept condition: in_valid && in_ready at the edge.
- in_ready is combinational from mode, in_sel, rr_ptr, out_valid and out_ready. It has no path from in_valid.
  - 00 addressed: in_ready = free[in_sel] if in_sel < N_OUT, otherwise 1.
  - 01 round-robin: in_ready = free[rr_ptr].
  - 10 broadcast: in_ready = AND of free[0..N_OUT-1].
  - 11 reserved: in_ready = 0. Nothing is accepted and buffers still drain.
- On accept:
  - Addressed, valid sel: load buffer[in_sel].
  - Addressed, in_sel ≥ N_OUT: load nothing and assert drop_err for the following cycle.
  - Round-robin: load buffer[rr_ptr], then advance rr_ptr. N_OUT-1 wraps to 0.
  - Broadcast: load every buffer with in_data.
- rr_ptr changes only on round-robin accepts. It holds its value across mode changes and resumes where it left off.
- mode and in_sel are sampled combinationally each cycle. A mode change does not affect beats already buffered.
- out_data[k] holds its last value while out_valid[k]=0. It is not cleared on pop.

## Timing

- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, rr_ptr=0, drop_err=0.
  - in_ready is forced to 0 while rst_n is low.
  - Buffered beats are lost.
- Release is synchronous to the next clk edge. in_ready may be 1 in the first cycle after deassertion.
- Latency: a beat accepted at edge T shows out_valid high from edge T until its pop edge. The register delay is 1 cycle.
- Throughput: 1 beat/cycle per channel while the consumer holds out_ready high. Round-robin reaches 1 beat/cycle aggregate.
- Stability: once asserted, out_valid[k] and out_data[k] stay stable until popped.
- Broadcast stall: any single stalled consumer stalls the input.
- drop_err is registered: high for exactly the cycle after the offending accept.

## Test plan

- Reset mid-traffic: WIDTH=8, N_OUT=4, fill all buffers, then pulse rst_n low between edges -> out_valid=0000, out_data=0 and rr_ptr=0 immediately, with no clk edge needed.
- Addressed with backpressure: sel=2, data 0xA5, out_ready=0 -> out_valid=0100 next cycle. Next beat to sel=2 sees in_ready=0. Raise out_ready[2] -> pop 0xA5 and accept the new beat on the same edge, so out_valid stays 0100 with the new data.
- Round-robin wrap: N_OUT=3, all out_ready=1, mode=01, 7 beats 0x10..0x16 -> channels 0,1,2,0,1,2,0 receive the data in order and rr_ptr ends at 1.
- Broadcast: mode=10, out_ready[3]=0 with channel 3 full -> in_ready=0. Release out_ready[3] -> the next accept of 0x3C sets out_valid=1111 with all out_data=0x3C.
- Invalid select: N_OUT=3, mode=00, in_sel=3, in_valid=1 -> in_ready=1, out_valid unchanged, drop_err high for exactly one cycle.
- Reserved mode: mode=11 with in_valid=1 -> in_ready=0 and no buffer loads, while existing beats still drain normally.
